l2_cache_arbiter: RTL

//  Shares the single L2 cache port between the L1 I-cache (read-only) and L1 D-cache (read/write).

---
 rtl/l2_arb_pkg.sv | 9 +
 rtl/rr_arbiter2.sv | 18 +
 rtl/l2_cache_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 port arbiter between the L1 I-cache and D-cache.
package l2_arb_pkg;

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
   typedef enum logic {ICACHE, DCACHE} requester_t;

   localparam int unsigned LINE_OFFSET_W = 5;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: req[0] is the I-cache, req[1] is the D-cache.
module rr_arbiter2
   import l2_arb_pkg::*;
(
   input  logic [1:0] req,
   input  requester_t last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      // On a tie the side that did not win last time goes first.
      if (req == 2'b11) begin
         gnt = (last == DCACHE) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/l2_cache_arbiter.sv
// Shares the single L2 CPU-side port between the I-cache and D-cache, one line at a time,
// round-robin on contention, with the response routed back to the granted side only.
module l2_cache_arbiter
   import l2_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              l2_read,
   output logic              l2_write,
   output logic [ADDR_W-1:0] l2_addr,
   output logic [LINE_W-1:0] l2_wdata,
   input  logic [LINE_W-1:0] l2_rdata,
   input  logic              l2_resp
);

   localparam logic [ADDR_W-1:0] LineMask = ~ADDR_W'((1 << LINE_OFFSET_W) - 1);

   arb_state_t        state_q;
   requester_t        last_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic              l2_read_q;
   logic              l2_write_q;
   logic              d_req;
   logic [1:0]        gnt;

   assign d_req = d_read | d_write;

   rr_arbiter2 u_rr (
      .req  ({d_req, i_read}),
      .last (last_q),
      .gnt  (gnt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         last_q     <= DCACHE;
         addr_q     <= '0;
         wdata_q    <= '0;
         l2_read_q  <= 1'b0;
         l2_write_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (gnt[0]) begin
                  state_q    <= SERVE_I;
                  last_q     <= ICACHE;
                  addr_q     <= i_addr & LineMask;
                  l2_read_q  <= 1'b1;
                  l2_write_q <= 1'b0;
               end else if (gnt[1]) begin
                  state_q    <= SERVE_D;
                  last_q     <= DCACHE;
                  addr_q     <= d_addr & LineMask;
                  wdata_q    <= d_wdata;
                  // A simultaneous read and write is resolved as a write.
                  l2_read_q  <= ~d_write;
                  l2_write_q <= d_write;
               end
            end
            SERVE_I, SERVE_D: begin
               if (l2_resp) begin
                  state_q    <= IDLE;
                  l2_read_q  <= 1'b0;
                  l2_write_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= IDLE;
               l2_read_q  <= 1'b0;
               l2_write_q <= 1'b0;
            end
         endcase
      end
   end

   assign l2_read  = l2_read_q;
   assign l2_write = l2_write_q;
   assign l2_addr  = addr_q;
   assign l2_wdata = wdata_q;

   // Response data passes straight through in the L2 resp cycle, zero otherwise.
   always_comb begin
      i_resp  = (state_q == SERVE_I) && l2_resp;
      d_resp  = (state_q == SERVE_D) && l2_resp;
      i_rdata = i_resp ? l2_rdata : '0;
      d_rdata = d_resp ? l2_rdata : '0;
   end

   a_no_rw_both: assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));
   a_no_idle_resp: assert property (@(posedge clk) disable iff (!rst)
                                    (state_q == IDLE) |-> !l2_resp);

endmodule
